mem_stage_unit: RTL and testbench

//  MEM stage of the 5-stage ARM pipeline. Sits directly downstream of the EX stage register and consumes its
//  wb_en/mem_r_en/mem_w_en/alu_res/val_Rm/dest.

---
 rtl/mem_stage_unit_pkg.sv | 18 +
 rtl/mem_stage_unit_wb_reg.sv | 64 ++++++
 rtl/mem_stage_unit.sv | 123 ++++++++++++
 tb/tb_mem_stage_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_unit_pkg.sv
// Shared widths, memory window and state encoding for the MEM pipeline stage.
package mem_stage_unit_pkg;
    localparam int unsigned REGISTER_LEN    = 32;
    localparam int unsigned REG_ADDRESS_LEN = 4;
    localparam int unsigned MEM_ADDR_BASE   = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // True when a byte address falls in the window of 2^maddr_w words starting at base.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input int unsigned maddr_w);
        return (addr >= base) && (addr < base + (64'd4 << maddr_w));
    endfunction
endpackage

// File: rtl/mem_stage_unit_wb_reg.sv
// MEM/WB pipeline register; a bubble clears the control bits and holds the data fields.
module mem_wb_stage_reg
    import mem_stage_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = REGISTER_LEN,
    parameter int unsigned RADDR_W = REG_ADDRESS_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bubble,
    input  logic               wb_en_in,
    input  logic               mem_r_en_in,
    input  logic [DATA_W-1:0]  alu_res_in,
    input  logic [DATA_W-1:0]  mem_data_in,
    input  logic [RADDR_W-1:0] dest_in,
    output logic               wb_en_out,
    output logic               mem_r_en_out,
    output logic [DATA_W-1:0]  alu_res_out,
    output logic [DATA_W-1:0]  mem_data_out,
    output logic [RADDR_W-1:0] dest_out
);
    logic               wb_en_q, wb_en_d;
    logic               mem_r_en_q, mem_r_en_d;
    logic [DATA_W-1:0]  alu_res_q, alu_res_d;
    logic [DATA_W-1:0]  mem_data_q, mem_data_d;
    logic [RADDR_W-1:0] dest_q, dest_d;

    always_comb begin
        wb_en_d    = 1'b0;
        mem_r_en_d = 1'b0;
        alu_res_d  = alu_res_q;
        mem_data_d = mem_data_q;
        dest_d     = dest_q;
        if (!bubble) begin
            wb_en_d    = wb_en_in;
            mem_r_en_d = mem_r_en_in;
            alu_res_d  = alu_res_in;
            mem_data_d = mem_data_in;
            dest_d     = dest_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            dest_q     <= '0;
        end else begin
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            alu_res_q  <= alu_res_d;
            mem_data_q <= mem_data_d;
            dest_q     <= dest_d;
        end
    end

    assign wb_en_out    = wb_en_q;
    assign mem_r_en_out = mem_r_en_q;
    assign alu_res_out  = alu_res_q;
    assign mem_data_out = mem_data_q;
    assign dest_out     = dest_q;
endmodule

// File: rtl/mem_stage_unit.sv
// MEM stage: LDR/STR over a req/ack memory port with wait-state FSM, watchdog and
// address-window check; stalls upstream via freeze and feeds the MEM/WB register.
module mem_stage_unit
    import mem_stage_unit_pkg::*;
#(
    parameter int unsigned DATA_W    = REGISTER_LEN,
    parameter int unsigned RADDR_W   = REG_ADDRESS_LEN,
    parameter int unsigned MADDR_W   = 16,
    parameter int unsigned ADDR_BASE = MEM_ADDR_BASE,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en_in,
    input  logic               mem_r_en_in,
    input  logic               mem_w_en_in,
    input  logic [DATA_W-1:0]  alu_res_in,
    input  logic [DATA_W-1:0]  val_Rm_in,
    input  logic [RADDR_W-1:0] dest_in,
    output logic               mem_req,
    output logic               mem_we,
    output logic [MADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               freeze,
    output logic               wb_en_hazard,
    output logic [RADDR_W-1:0] dest_hazard,
    output logic               wb_en_out,
    output logic               mem_r_en_out,
    output logic [DATA_W-1:0]  alu_res_out,
    output logic [DATA_W-1:0]  mem_data_out,
    output logic [RADDR_W-1:0] dest_out,
    output logic               mem_err
);
    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              access, in_win, req, complete;
    logic [DATA_W-1:0] cpl_data, wb_data;

    assign access = mem_r_en_in | mem_w_en_in;
    assign in_win = in_window(64'(alu_res_in), 64'(ADDR_BASE), MADDR_W);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        req      = 1'b0;
        complete = 1'b0;
        cpl_data = '0;
        case (state_q)
            IDLE: begin
                // An ack seen here is never sampled, so the minimum access latency is one cycle.
                if (access && in_win) begin
                    req     = 1'b1;
                    state_d = WAIT;
                    cnt_d   = '0;
                end else if (access) begin
                    complete = 1'b1;
                    err_d    = 1'b1;
                end
            end
            WAIT: begin
                req   = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (mem_ack) begin
                    complete = 1'b1;
                    cpl_data = mem_rdata;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    complete = 1'b1;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_req      = req & rst;
    assign mem_we       = mem_w_en_in;
    assign mem_addr     = MADDR_W'((alu_res_in - DATA_W'(ADDR_BASE)) >> 2);
    assign mem_wdata    = val_Rm_in;
    assign freeze       = access & ~complete;
    assign wb_en_hazard = wb_en_in;
    assign dest_hazard  = dest_in;
    assign mem_err      = err_q;
    // Simultaneous read/write is treated as a store, so it never returns load data.
    assign wb_data      = (mem_r_en_in & ~mem_w_en_in) ? cpl_data : '0;

    mem_wb_stage_reg #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .bubble       (freeze),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .alu_res_in   (alu_res_in),
        .mem_data_in  (wb_data),
        .dest_in      (dest_in),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .alu_res_out  (alu_res_out),
        .mem_data_out (mem_data_out),
        .dest_out     (dest_out)
    );
endmodule

// File: tb/tb_mem_stage_unit.sv
// Scoreboard bench for mem_stage_unit: the driver pushes per-cycle expectations from an
// instruction-level latency model; a negedge monitor pops and compares.
module tb_mem_stage_unit;
    localparam int TO   = 15;
    localparam int BASE = 1024;
    localparam longint WIN_END = 1024 + 4 * 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
    logic [31:0] alu_res_in = '0, val_Rm_in = '0, mem_rdata = '0;
    logic [3:0]  dest_in = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, freeze, wb_en_hazard, wb_en_out, mem_r_en_out, mem_err;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, alu_res_out, mem_data_out;
    logic [3:0]  dest_hazard, dest_out;

    mem_stage_unit #(
        .DATA_W    (32),
        .RADDR_W   (4),
        .MADDR_W   (16),
        .ADDR_BASE (BASE),
        .TIMEOUT   (TO)
    ) dut (
        .clk (clk), .rst (rst),
        .wb_en_in (wb_en_in), .mem_r_en_in (mem_r_en_in), .mem_w_en_in (mem_w_en_in),
        .alu_res_in (alu_res_in), .val_Rm_in (val_Rm_in), .dest_in (dest_in),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata), .mem_ack (mem_ack), .freeze (freeze),
        .wb_en_hazard (wb_en_hazard), .dest_hazard (dest_hazard),
        .wb_en_out (wb_en_out), .mem_r_en_out (mem_r_en_out), .alu_res_out (alu_res_out),
        .mem_data_out (mem_data_out), .dest_out (dest_out), .mem_err (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        frz, req, we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        wbh;
        logic [3:0]  dsth;
        logic        wb, r;
        logic [31:0] alu, data;
        logic [3:0]  dst;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Architectural view of the MEM/WB register and error flag as seen after the last edge.
    logic        m_wb = 0, m_r = 0, m_err = 0;
    logic [31:0] m_alu = '0, m_data = '0;
    logic [3:0]  m_dst = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("freeze", 32'(freeze), 32'(e.frz));
                chk("mem_req", 32'(mem_req), 32'(e.req));
                if (e.req) begin
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    chk("mem_wdata", mem_wdata, e.wdata);
                end
                chk("wb_en_hazard", 32'(wb_en_hazard), 32'(e.wbh));
                chk("dest_hazard", 32'(dest_hazard), 32'(e.dsth));
                chk("wb_en_out", 32'(wb_en_out), 32'(e.wb));
                chk("mem_r_en_out", 32'(mem_r_en_out), 32'(e.r));
                chk("alu_res_out", alu_res_out, e.alu);
                chk("mem_data_out", mem_data_out, e.data);
                chk("dest_out", 32'(dest_out), 32'(e.dst));
                chk("mem_err", 32'(mem_err), 32'(e.err));
            end
        end
    end

    // One clock of stimulus: drive EX inputs, push this cycle's expectation, then advance the model.
    task automatic cycle(input logic wb, r, w, input logic [31:0] alu, rm, input logic [3:0] dst,
                         input logic ack, input logic [31:0] rd,
                         input logic frz, req, input logic [31:0] cdata, input logic set_err);
        exp_t e;
        @(posedge clk); #1;
        wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
        alu_res_in = alu; val_Rm_in = rm; dest_in = dst;
        mem_ack = ack; mem_rdata = rd;
        e.frz = frz; e.req = req; e.we = w;
        e.addr = 16'((alu - 32'(BASE)) >> 2); e.wdata = rm;
        e.wbh = wb; e.dsth = dst;
        e.wb = m_wb; e.r = m_r; e.alu = m_alu; e.data = m_data; e.dst = m_dst; e.err = m_err;
        sb.push_back(e);
        if (frz) begin
            m_wb = 0; m_r = 0;
        end else begin
            m_wb = wb; m_r = r; m_alu = alu; m_dst = dst;
            m_data = (r && !w) ? cdata : 32'd0;
        end
        if (set_err) m_err = 1;
    endtask

    // One instruction: nw = WAIT cycles that pass before the ack cycle; nw > TO means no ack in time.
    task automatic run_instr(input logic wb, r, w, input logic [31:0] alu, rm, input logic [3:0] dst,
                             input int nw, input logic [31:0] rd, input logic stray);
        bit access, inwin, to;
        int lat;
        access = r | w;
        inwin  = (longint'(alu) >= longint'(BASE)) && (longint'(alu) < WIN_END);
        if (!access) begin
            cycle(wb, r, w, alu, rm, dst, stray, $urandom, 0, 0, 32'd0, 0);
        end else if (!inwin) begin
            cycle(wb, r, w, alu, rm, dst, stray, $urandom, 0, 0, 32'd0, 1);
        end else begin
            to  = nw > TO;
            lat = to ? TO + 1 : nw + 1;
            for (int c = 0; c <= lat; c++) begin
                logic ack;
                ack = (c == 0) ? stray : (!to && c == nw + 1);
                cycle(wb, r, w, alu, rm, dst, ack, (ack && c != 0) ? rd : $urandom,
                      c < lat, 1, to ? 32'd0 : rd, to && c == lat);
            end
        end
    endtask

    // Async reset asserted between edges with EX inputs cleared; released before the next edge.
    task automatic reset_cycle();
        exp_t e;
        @(posedge clk); #2;
        rst = 0;
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        alu_res_in = '0; val_Rm_in = '0; dest_in = '0; mem_ack = 0; mem_rdata = '0;
        m_wb = 0; m_r = 0; m_alu = '0; m_data = '0; m_dst = '0; m_err = 0;
        e = '{frz: 0, req: 0, we: 0, addr: '0, wdata: '0, wbh: 0, dsth: '0,
              wb: 0, r: 0, alu: '0, data: '0, dst: '0, err: 0};
        sb.push_back(e);
        @(negedge clk); #1;
        rst = 1;
    endtask

    initial begin : driver
        reset_cycle();
        run_instr(1, 0, 0, 32'h55, 32'h0, 4'd3, 0, 32'h0, 1'b1);
        run_instr(1, 1, 0, 32'd1032, 32'h0, 4'd5, 2, 32'hDEADBEEF, 1'b0);
        run_instr(0, 0, 1, 32'd1024, 32'd7, 4'd6, 1, 32'h12345678, 1'b1);
        run_instr(1, 1, 0, 32'd100, 32'h0, 4'd2, 0, 32'h0, 1'b0);
        run_instr(1, 0, 0, 32'h77, 32'h0, 4'd1, 0, 32'h0, 1'b1);
        reset_cycle();
        run_instr(1, 1, 0, 32'd1023, 32'h0, 4'd4, 0, 32'h0, 1'b0);
        reset_cycle();
        run_instr(1, 1, 0, 32'd263167, 32'h0, 4'd7, 0, 32'hCAFEF00D, 1'b1);
        run_instr(1, 1, 0, 32'd263168, 32'h0, 4'd8, 0, 32'h0, 1'b0);
        reset_cycle();
        run_instr(1, 1, 0, 32'd2048, 32'h0, 4'd9, TO + 5, 32'hAAAA5555, 1'b1);
        run_instr(1, 0, 0, 32'h99, 32'h0, 4'd10, 0, 32'h0, 1'b1);
        run_instr(1, 1, 1, 32'd4096, 32'd33, 4'd11, 3, 32'h0BADBEEF, 1'b0);
        // Reset in the middle of a wait: two frozen cycles, then reset.
        cycle(1, 1, 0, 32'd1040, 32'h0, 4'd12, 0, $urandom, 1, 1, 32'd0, 0);
        cycle(1, 1, 0, 32'd1040, 32'h0, 4'd12, 0, $urandom, 1, 1, 32'd0, 0);
        reset_cycle();
        run_instr(1, 1, 0, 32'd1040, 32'h0, 4'd12, 1, 32'h600DD00D, 1'b0);
        for (int i = 0; i < 300; i++) begin
            int kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 5));
            a = 32'(BASE) + $urandom_range(0, 262143);
            if (kind == 4) a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1023)
                                                           : 32'd263168 + $urandom_range(0, 32'h7fffffff);
            run_instr(1'($urandom), kind == 1 || kind == 3 || kind == 5 || (kind == 4 && $urandom_range(0, 1) == 1),
                      kind == 2 || kind == 3, (kind == 0) ? $urandom : a, $urandom, 4'($urandom),
                      int'($urandom_range(0, TO + 3)), $urandom, 1'($urandom));
        end
        repeat (3) @(posedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
